irq_controller: RTL and testbench

Programmable interrupt controller that sits directly upstream of the RV32IC core's interrupt inputs. It captures eight external request lines, holds them as pending, applies a software mask and fixed priority, and presents one interrupt number at a time to the core. It then tracks the core's acknowledge and end-of-interrupt handshake, so the core sees exactly one request per service.

---
 rtl/irq_pkg.sv | 23 ++
 rtl/irq_prio_enc.sv | 31 +++
 rtl/irq_controller.sv | 178 +++++++++++++++++
 tb/tb_irq_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the programmable interrupt controller.
//   NUM_SRC_DEF : default number of request lines (index 0 = highest priority)
//   ID_W_DEF    : default width of an interrupt number (clog2(NUM_SRC_DEF))
//   irq_state_t : presentation / service FSM state
// Optional feature macro used by the controller: IRQ_LEVEL_MODE_EN
// -----------------------------------------------------------------------------
package irq_pkg;

   localparam int NUM_SRC_DEF = 8;
   localparam int ID_W_DEF    = 3;

   // IDLE  : nothing presented, looking for an eligible source
   // REQ   : one number presented to the core, waiting for int_ack
   // INSVC : core is servicing, waiting for int_eoi (no nesting)
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      INSVC = 2'd2
   } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational fixed-priority encoder: the lowest set index wins.
// Ports:
//   i_req   [NUM_SRC-1:0] : request vector (already masked by the caller)
//   o_valid               : at least one bit of i_req is set
//   o_idx   [ID_W-1:0]    : index of the lowest set bit (0 when none set)
// -----------------------------------------------------------------------------
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int ID_W    = ID_W_DEF
) (
   input  logic [NUM_SRC-1:0] i_req,
   output logic               o_valid,
   output logic [ID_W-1:0]    o_idx
);

   always_comb begin
      o_valid = |i_req;
      o_idx   = '0;
      // Scan from the top down so the last (lowest) set index overwrites.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Programmable interrupt controller in front of the core's interrupt inputs.
// Captures request lines into a pending register, applies a software mask and
// fixed priority (index 0 highest), presents one interrupt number at a time
// and tracks the ack / end-of-interrupt handshake so each service sees exactly
// one request.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   int_req    : request lines (already in the clk domain)
//   mask_we    : mask register write strobe
//   mask_wdata : new mask value, bit=1 enables the source
//   int_ack    : core accepts the presented interrupt (pulse)
//   int_eoi    : core finished servicing the current interrupt (pulse)
//   int_o      : interrupt request to the core
//   int_num_o  : number of the presented / in-service source
//   pending_o  : pending register, for status reads
//   busy_o     : high while an interrupt is in service
//
// Configuration macro: IRQ_LEVEL_MODE_EN
//   defined     : level-sensitive sources, pending follows int_req each cycle
//                 and ack does not clear it.
//   not defined : rising-edge capture into a sticky pending register, cleared
//                 by the ack of that source.
// -----------------------------------------------------------------------------
module irq_controller
   import irq_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int ID_W    = ID_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] int_req,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   input  logic               int_ack,
   input  logic               int_eoi,
   output logic               int_o,
   output logic [ID_W-1:0]    int_num_o,
   output logic [NUM_SRC-1:0] pending_o,
   output logic               busy_o
);

   irq_state_t         r_state;
   logic               r_int;
   logic [ID_W-1:0]    r_int_num;
   logic               r_busy;
   logic [NUM_SRC-1:0] r_mask;
   logic [NUM_SRC-1:0] r_pending;

   logic [NUM_SRC-1:0] w_eligible;
   logic               w_win_valid;
   logic [ID_W-1:0]    w_win_idx;
   logic               w_ack_take;

   // An ack only counts while a number is actually presented.
   assign w_ack_take = (r_state == REQ) && int_ack;

   // Mask is the registered value, so an unmask write becomes effective on
   // the cycle after the write.
   assign w_eligible = r_pending & r_mask;

   irq_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_prio_enc (
      .i_req   (w_eligible),
      .o_valid (w_win_valid),
      .o_idx   (w_win_idx)
   );

   // -------------------------------------------------------------------------
   // Mask register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mask <= '1;
      end else if (mask_we) begin
         r_mask <= mask_wdata;
      end
   end

   // -------------------------------------------------------------------------
   // Pending capture
   // -------------------------------------------------------------------------
`ifdef IRQ_LEVEL_MODE_EN

   // Level mode: pending simply mirrors the lines; the source is responsible
   // for dropping its line before EOI or it is presented again.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= int_req;
      end
   end

`else

   logic [NUM_SRC-1:0] r_req_q;
   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_clr;

   // r_req_q is cleared by reset, so a line held high through reset shows up
   // as a fresh edge on the first cycle afterwards.
   assign w_edge = int_req & ~r_req_q;

   // One-hot clear of the acknowledged source.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_clr
      assign w_clr[gi] = w_ack_take && (r_int_num == ID_W'(gi));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_q   <= '0;
         r_pending <= '0;
      end else begin
         r_req_q   <= int_req;
         // Edge is OR-ed in after the clear so a coincident new edge wins.
         r_pending <= (r_pending & ~w_clr) | w_edge;
      end
   end

`endif

   // -------------------------------------------------------------------------
   // Presentation / service FSM with registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_int     <= 1'b0;
         r_int_num <= '0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_win_valid) begin
                  r_int_num <= w_win_idx;
                  r_int     <= 1'b1;
                  r_state   <= REQ;
               end
            end
            REQ: begin
               // Number is frozen here: neither a higher-priority arrival nor
               // masking the presented source retracts the request.
               if (int_ack) begin
                  r_int   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= INSVC;
               end
            end
            INSVC: begin
               // int_num_o keeps naming the in-service source until the next
               // presentation.
               if (int_eoi) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_int   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign int_o     = r_int;
   assign int_num_o = r_int_num;
   assign pending_o = r_pending;
   assign busy_o    = r_busy;

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
// Bench for irq_controller in its default (edge-triggered) build. A behavioural
// model tracks pending requests as a bit array plus two flags ("presenting",
// "in service"); every cycle all four outputs are compared with it, and the
// scenarios of interest also get explicit constant expectations.
// -----------------------------------------------------------------------------
module tb_irq_controller;

   localparam int NS = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [NS-1:0] int_req;
   logic          mask_we;
   logic [NS-1:0] mask_wdata;
   logic          int_ack;
   logic          int_eoi;
   logic          int_o;
   logic [IW-1:0] int_num_o;
   logic [NS-1:0] pending_o;
   logic          busy_o;

   int errors = 0;
   int checks = 0;

   irq_controller #(.NUM_SRC(NS), .ID_W(IW)) dut (
      .clk        (clk),
      .rst        (rst),
      .int_req    (int_req),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .int_ack    (int_ack),
      .int_eoi    (int_eoi),
      .int_o      (int_o),
      .int_num_o  (int_num_o),
      .pending_o  (pending_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit          m_pend [NS];
   bit          m_mask [NS];
   bit          m_prev [NS];
   bit          m_presenting;
   bit          m_serving;
   int          m_num;

   function automatic int lowest_eligible();
      for (int i = 0; i < NS; i++)
         if (m_pend[i] && m_mask[i]) return i;
      return -1;
   endfunction

   function automatic logic [NS-1:0] pend_vec();
      logic [NS-1:0] v;
      for (int i = 0; i < NS; i++) v[i] = m_pend[i];
      return v;
   endfunction

   // Advance the model by one clock edge using the inputs present at the edge.
   function automatic void model_edge(input bit r, input logic [NS-1:0] req,
                                      input bit we, input logic [NS-1:0] wd,
                                      input bit ack, input bit eoi);
      int  win;
      bit  new_pend [NS];
      if (r) begin
         for (int i = 0; i < NS; i++) begin
            m_pend[i] = 0; m_mask[i] = 1; m_prev[i] = 0;
         end
         m_presenting = 0; m_serving = 0; m_num = 0;
         return;
      end
      win = lowest_eligible();
      for (int i = 0; i < NS; i++) begin
         new_pend[i] = m_pend[i];
         if (m_presenting && ack && m_num == i) new_pend[i] = 0;
         if (req[i] && !m_prev[i]) new_pend[i] = 1;
      end
      if (m_presenting) begin
         if (ack) begin m_presenting = 0; m_serving = 1; end
      end else if (m_serving) begin
         if (eoi) m_serving = 0;
      end else if (win >= 0) begin
         m_num = win; m_presenting = 1;
      end
      for (int i = 0; i < NS; i++) begin
         m_pend[i] = new_pend[i];
         m_prev[i] = req[i];
         if (we) m_mask[i] = wd[i];
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, step the model, sample #1 after the edge and
   // compare every output with the model.
   task automatic cyc(input bit r, input logic [NS-1:0] req,
                      input bit we = 0, input logic [NS-1:0] wd = '0,
                      input bit ack = 0, input bit eoi = 0);
      rst = r; int_req = req; mask_we = we; mask_wdata = wd;
      int_ack = ack; int_eoi = eoi;
      model_edge(r, req, we, wd, ack, eoi);
      @(posedge clk);
      #1;
      check("int_o",     32'(int_o),     32'(m_presenting));
      check("int_num_o", 32'(int_num_o), 32'(m_num));
      check("pending_o", 32'(pending_o), 32'(pend_vec()));
      check("busy_o",    32'(busy_o),    32'(m_serving));
   endtask

   initial begin
      logic [NS-1:0] rq;
      rst = 1; int_req = '0; mask_we = 0; mask_wdata = '0; int_ack = 0; int_eoi = 0;

      // Reset state
      cyc(1, 8'h00);
      cyc(1, 8'h00);
      check("rst_int_o", 32'(int_o), 0);
      check("rst_num",   32'(int_num_o), 0);
      check("rst_pend",  32'(pending_o), 0);
      check("rst_busy",  32'(busy_o), 0);

      // Single source 4: presented two cycles after the rising edge
      cyc(0, 8'h10);
      check("t1_pend", 32'(pending_o), 32'h10);
      check("t1_int_early", 32'(int_o), 0);
      cyc(0, 8'h10);
      check("t1_int", 32'(int_o), 1);
      check("t1_num", 32'(int_num_o), 4);
      cyc(0, 8'h10, 0, 0, 1, 0);
      check("t1_ack_pend", 32'(pending_o), 0);
      check("t1_ack_busy", 32'(busy_o), 1);
      check("t1_ack_int",  32'(int_o), 0);
      cyc(0, 8'h10, 0, 0, 0, 1);
      check("t1_eoi_busy", 32'(busy_o), 0);
      cyc(0, 8'h00);

      // Two sources together: 2 first, then 7 one cycle after EOI
      cyc(0, 8'h84);
      cyc(0, 8'h84);
      check("t2_num2", 32'(int_num_o), 2);
      cyc(0, 8'h84, 0, 0, 1, 0);
      cyc(0, 8'h84, 0, 0, 0, 1);
      check("t2_idle", 32'(int_o), 0);
      cyc(0, 8'h84);
      check("t2_int7", 32'(int_o), 1);
      check("t2_num7", 32'(int_num_o), 7);
      cyc(0, 8'h84, 0, 0, 1, 0);
      cyc(0, 8'h00, 0, 0, 0, 1);

      // Masked source latches pending, is presented after unmask
      cyc(0, 8'h00, 1, 8'hFB);
      cyc(0, 8'h04);
      cyc(0, 8'h04);
      cyc(0, 8'h04);
      check("t3_masked_int", 32'(int_o), 0);
      check("t3_masked_pend", 32'(pending_o), 32'h04);
      cyc(0, 8'h04, 1, 8'hFF);
      check("t3_still_int", 32'(int_o), 0);
      cyc(0, 8'h04);
      check("t3_unmask_int", 32'(int_o), 1);
      check("t3_unmask_num", 32'(int_num_o), 2);
      cyc(0, 8'h00, 0, 0, 1, 0);
      cyc(0, 8'h00, 0, 0, 0, 1);

      // Priority frozen in REQ: 5 stays presented despite an edge on 0
      cyc(0, 8'h20);
      cyc(0, 8'h20);
      cyc(0, 8'h21);
      check("t4_frozen", 32'(int_num_o), 5);
      cyc(0, 8'h21);
      check("t4_frozen2", 32'(int_num_o), 5);
      cyc(0, 8'h21, 0, 0, 1, 0);
      check("t4_pend0", 32'(pending_o), 32'h01);
      cyc(0, 8'h21);
      check("t4_no_nest", 32'(int_o), 0);
      cyc(0, 8'h21, 0, 0, 0, 1);
      cyc(0, 8'h21);
      check("t4_num0", 32'(int_num_o), 0);
      check("t4_int0", 32'(int_o), 1);
      cyc(0, 8'h00, 0, 0, 1, 0);
      cyc(0, 8'h00, 0, 0, 0, 1);

      // Reset while in service with pending 03, then stray ack / eoi
      cyc(0, 8'h04);
      cyc(0, 8'h04);
      cyc(0, 8'h04, 0, 0, 1, 0);
      cyc(0, 8'h07);
      check("t5_pend03", 32'(pending_o), 32'h03);
      check("t5_busy",   32'(busy_o), 1);
      cyc(1, 8'h07);
      check("t5_rst_all", 32'({int_o, int_num_o, pending_o, busy_o}), 0);
      cyc(0, 8'h00, 0, 0, 1, 0);
      cyc(0, 8'h00, 0, 0, 0, 1);
      check("t5_stray", 32'({int_o, int_num_o, pending_o, busy_o}), 0);

      // New edge on 3 coincident with ack of 3: set wins, re-presented
      cyc(0, 8'h08);
      cyc(0, 8'h08);
      check("t6_num3", 32'(int_num_o), 3);
      cyc(0, 8'h00);
      cyc(0, 8'h08, 0, 0, 1, 0);
      check("t6_pend_kept", 32'(pending_o), 32'h08);
      check("t6_busy", 32'(busy_o), 1);
      cyc(0, 8'h08, 0, 0, 0, 1);
      cyc(0, 8'h08);
      check("t6_repr_int", 32'(int_o), 1);
      check("t6_repr_num", 32'(int_num_o), 3);
      cyc(0, 8'h08, 0, 0, 1, 0);
      cyc(0, 8'h08, 0, 0, 0, 1);

      // Randomized traffic against the model
      rq = 8'h08;
      for (int n = 0; n < 600; n++) begin
         rq = rq ^ NS'($urandom & $urandom & $urandom);
         cyc(($urandom % 97) == 0, rq,
             ($urandom % 12) == 0, NS'($urandom | $urandom),
             ($urandom % 3) == 0, ($urandom % 3) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
